// File: rtl/axis_read_pkg.sv
// Shared widths for the AXI-Stream read FIFO.
// Pointer width and stored-entry width helpers.
package axis_read_pkg;

  function automatic int ptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  // One extra bit stores TLAST next to the data.
  function automatic int entry_w(input int bus_width);
    return bus_width + 1;
  endfunction

endpackage

// File: rtl/axi_stream_read_fifo_if.sv
// Upstream AXI-Stream and downstream FWFT signal bundle.
// slave = FIFO side, master = stream source / consumer side.
interface axi_stream_read_fifo_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 2
);
  logic                  tvalid;
  logic                  tready;
  logic [BUS_WIDTH-1:0]  tdata;
  logic                  tlast;
  logic [BUS_WIDTH-1:0]  rdata;
  logic                  rlast;
  logic                  enable;
  logic                  rd_en;
  logic [DEPTH_LOG2:0]   count;
  logic                  frame_done;

  modport slave (
    input  tvalid, tdata, tlast, rd_en,
    output tready, rdata, rlast, enable,
    output count, frame_done
  );

  modport master (
    output tvalid, tdata, tlast, rd_en,
    input  tready, rdata, rlast, enable,
    input  count, frame_done
  );
endinterface

// File: rtl/axis_sync_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read.
// Not reset; contents are only observed through valid pointers.
module axis_sync_fifo_mem #(
  parameter int WIDTH      = 17,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_stream_read_fifo.sv
// AXI-Stream slave buffering beats in a FWFT FIFO.
// Holds pointers, flags, registered tready and frame_done pulse.
module axi_stream_read_fifo
  import axis_read_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic                  i_tvalid,
  output logic                  o_tready,
  input  logic [BUS_WIDTH-1:0]  i_data_bus,
  input  logic                  i_tlast,
  output logic [BUS_WIDTH-1:0]  o_transmitted_data,
  output logic                  o_tlast,
  output logic                  o_enable,
  input  logic                  i_rd_en,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_frame_done
);

  localparam int PW = ptr_w(DEPTH_LOG2);
  localparam int EW = entry_w(BUS_WIDTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(2**DEPTH_LOG2);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count, count_d;
  logic          tready_q, tready_d;
  logic          done_q, done_d;
  logic          empty, push, pop;
  logic [EW-1:0] head;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = i_tvalid && tready_q;
  assign pop   = !empty && i_rd_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count + PW'(push) - PW'(pop);
    tready_d = (count_d < DEPTH_C);
    done_d   = pop && head[EW-1];
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tready_q <= tready_d;
      done_q   <= done_d;
    end
  end

  axis_sync_fifo_mem #(
    .WIDTH      (EW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i ({i_tlast, i_data_bus}),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (head)
  );

  assign o_tready           = tready_q;
  assign o_enable           = !empty;
  assign o_count            = count;
  assign o_transmitted_data = head[BUS_WIDTH-1:0];
  assign o_tlast            = head[EW-1];
  assign o_frame_done       = done_q;

endmodule

// File: tb/tb_axi_stream_read_fifo.sv
// Directed self-checking bench for axi_stream_read_fifo.
// Drives and samples on the falling clock edge.
module tb_axi_stream_read_fifo;

  localparam int BW = 16;
  localparam int DL = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  axi_stream_read_fifo_if #(.BUS_WIDTH(BW), .DEPTH_LOG2(DL)) bus ();

  axi_stream_read_fifo #(.BUS_WIDTH(BW), .DEPTH_LOG2(DL)) dut (
    .i_clk              (clk),
    .i_aresetn          (rst_n),
    .i_tvalid           (bus.tvalid),
    .o_tready           (bus.tready),
    .i_data_bus         (bus.tdata),
    .i_tlast            (bus.tlast),
    .o_transmitted_data (bus.rdata),
    .o_tlast            (bus.rlast),
    .o_enable           (bus.enable),
    .i_rd_en            (bus.rd_en),
    .o_count            (bus.count),
    .o_frame_done       (bus.frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [BW-1:0] d, input logic l);
    bus.tvalid = 1'b1;
    bus.tdata  = d;
    bus.tlast  = l;
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.tvalid = 1'b0;
    bus.tdata  = '0;
    bus.tlast  = 1'b0;
    bus.rd_en  = 1'b0;

    // 1: reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tready", 32'(bus.tready), 0);
    end
    check("rst_enable", 32'(bus.enable), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_done", 32'(bus.frame_done), 0);
    rst_n = 1'b1;
    #1 check("rel_tready_pre", 32'(bus.tready), 0);
    @(negedge clk);
    check("rel_tready", 32'(bus.tready), 1);
    check("rel_enable", 32'(bus.enable), 0);
    check("rel_count", 32'(bus.count), 0);

    // 2: fill back-to-back, 5th held off
    for (int i = 1; i <= 4; i++) begin
      beat(BW'(i), 1'b0);
      check("fill_count", 32'(bus.count), 32'(i));
    end
    check("full_tready", 32'(bus.tready), 0);
    check("full_head", 32'(bus.rdata), 32'h1);
    check("full_enable", 32'(bus.enable), 1);
    beat(16'h0005, 1'b0);
    check("held_count", 32'(bus.count), 4);
    check("held_head", 32'(bus.rdata), 32'h1);

    // 3: drain from full while 5th beat waits
    bus.rd_en = 1'b1;
    tick();
    check("pop1_head", 32'(bus.rdata), 32'h2);
    check("pop1_count", 32'(bus.count), 3);
    check("pop1_tready", 32'(bus.tready), 1);
    tick();
    bus.tvalid = 1'b0;
    check("pop2_head", 32'(bus.rdata), 32'h3);
    check("pop2_count", 32'(bus.count), 3);
    tick();
    check("pop3_head", 32'(bus.rdata), 32'h4);
    check("pop3_count", 32'(bus.count), 2);
    tick();
    bus.rd_en = 1'b0;
    check("pop4_head", 32'(bus.rdata), 32'h5);
    check("pop4_count", 32'(bus.count), 1);
    check("pop4_done", 32'(bus.frame_done), 0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("drain_count", 32'(bus.count), 0);
    check("drain_enable", 32'(bus.enable), 0);

    // 4: streaming push+pop, pointers wrap
    bus.rd_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      beat(BW'(k - 1), 1'b0);
      check("stream_head", 32'(bus.rdata), 32'(k - 1));
      check("stream_count", 32'(bus.count), 1);
    end
    bus.tvalid = 1'b0;
    tick();
    bus.rd_en = 1'b0;
    check("stream_empty", 32'(bus.count), 0);
    check("stream_ready", 32'(bus.tready), 1);

    // 5: 3-beat frame with TLAST on the last beat
    beat(16'h000A, 1'b0);
    beat(16'h000B, 1'b0);
    beat(16'h000C, 1'b1);
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    check("frm_count", 32'(bus.count), 3);
    check("frm_headA", 32'(bus.rdata), 32'hA);
    check("frm_lastA", 32'(bus.rlast), 0);
    bus.rd_en = 1'b1;
    tick();
    check("frm_headB", 32'(bus.rdata), 32'hB);
    check("frm_lastB", 32'(bus.rlast), 0);
    check("frm_doneB", 32'(bus.frame_done), 0);
    tick();
    check("frm_headC", 32'(bus.rdata), 32'hC);
    check("frm_lastC", 32'(bus.rlast), 1);
    check("frm_doneC", 32'(bus.frame_done), 0);
    tick();
    bus.rd_en = 1'b0;
    check("frm_done", 32'(bus.frame_done), 1);
    check("frm_empty", 32'(bus.enable), 0);
    tick();
    check("frm_done_off", 32'(bus.frame_done), 0);

    // 6: async reset mid-frame with 2 beats buffered
    beat(16'h0011, 1'b0);
    beat(16'h0022, 1'b0);
    check("mid_count", 32'(bus.count), 2);
    bus.tdata = 16'h0033;
    #2 rst_n = 1'b0;
    #1;
    check("arst_enable", 32'(bus.enable), 0);
    check("arst_count", 32'(bus.count), 0);
    check("arst_tready", 32'(bus.tready), 0);
    @(negedge clk);
    bus.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_enable", 32'(bus.enable), 0);
    check("post_count", 32'(bus.count), 0);
    check("post_tready", 32'(bus.tready), 1);
    beat(16'h0044, 1'b0);
    bus.tvalid = 1'b0;
    check("post_head", 32'(bus.rdata), 32'h44);
    check("post_count1", 32'(bus.count), 1);
    check("post_done", 32'(bus.frame_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
